// File: rtl/frame_pkg.sv
// Shared definitions for the frame writer/reader pair: FSM encoding and JPEG marker bytes.
package frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DATA = 3'd3,
    ST_SEND_LO   = 3'd4,
    ST_SEND_HI   = 3'd5,
    ST_FINISH    = 3'd6
  } frame_state_t;

  localparam logic [7:0] MARK_FF  = 8'hFF;
  localparam logic [7:0] MARK_EOI = 8'hD9;

  // The end-of-image marker may end up in the low byte of the last word.
  function automatic logic eoi_in_low(input logic [15:0] w);
    return w[7:0] == MARK_EOI;
  endfunction

endpackage

// File: rtl/frame_reader.sv
// Reads a stored frame out of SRAM word by word and streams it as bytes, low byte first.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for frame_end (must have been seen low since last FINISH)
// REQ       | waiting for SRAM idle, then pulse sram_start low
// WAIT_BUSY | waiting for SRAM to accept the request (ready drops)
// WAIT_DATA | waiting for read data (ready returns), captures the word
// SEND_LO   | presenting word[7:0]
// SEND_HI   | presenting word[15:8]
// FINISH    | one-cycle done / writer re-arm pulse
module frame_reader
  import frame_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_end,
  input  logic [15:0] stop_addr,
  input  logic        sram_ready,
  input  logic [15:0] sram_rdata,
  output logic [15:0] sram_addr,
  output logic        sram_rw,
  output logic        sram_start,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        writer_reset_n
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  frame_state_t state, state_nxt;

  logic [15:0]   addr_q;
  logic [15:0]   word_q;
  logic [7:0]    byte_q;
  logic [TW-1:0] tmo_q;
  logic          error_q;
  logic          armed_q;

  logic at_stop;
  logic last_lo;
  logic tmo_zero;
  logic timeout_evt;

  assign at_stop     = (addr_q == stop_addr);
  assign last_lo     = at_stop && eoi_in_low(word_q);
  assign tmo_zero    = (tmo_q == '0);
  assign timeout_evt = tmo_zero &&
                       (((state == ST_WAIT_BUSY) &&  sram_ready) ||
                        ((state == ST_WAIT_DATA) && !sram_ready));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:      if (frame_end && armed_q) state_nxt = ST_REQ;
      ST_REQ:       if (sram_ready) state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!sram_ready)      state_nxt = ST_WAIT_DATA;
        else if (timeout_evt) state_nxt = ST_FINISH;
      end
      ST_WAIT_DATA: begin
        if (sram_ready)       state_nxt = ST_SEND_LO;
        else if (timeout_evt) state_nxt = ST_FINISH;
      end
      ST_SEND_LO:   if (byte_ready) state_nxt = last_lo ? ST_FINISH : ST_SEND_HI;
      ST_SEND_HI:   if (byte_ready) state_nxt = at_stop ? ST_FINISH : ST_REQ;
      ST_FINISH:    state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sram_start     = 1'b1;
    byte_valid     = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    writer_reset_n = 1'b1;
    unique case (state)
      ST_IDLE:      ;
      ST_REQ:       begin busy = 1'b1; sram_start = ~sram_ready; end
      ST_WAIT_BUSY: busy = 1'b1;
      ST_WAIT_DATA: busy = 1'b1;
      ST_SEND_LO:   begin busy = 1'b1; byte_valid = 1'b1; end
      ST_SEND_HI:   begin busy = 1'b1; byte_valid = 1'b1; end
      ST_FINISH:    begin done = 1'b1; writer_reset_n = 1'b0; end
      default:      ;
    endcase
  end

  // armed_q blocks a level that stayed high through FINISH from restarting a readout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      word_q  <= '0;
      byte_q  <= '0;
      tmo_q   <= '0;
      error_q <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!frame_end) armed_q <= 1'b1;
          if (frame_end && armed_q) addr_q <= '0;
        end
        ST_REQ: tmo_q <= TMO_LOAD;
        ST_WAIT_BUSY, ST_WAIT_DATA: begin
          if (!tmo_zero)   tmo_q   <= tmo_q - TW'(1);
          if (timeout_evt) error_q <= 1'b1;
          if ((state == ST_WAIT_DATA) && sram_ready) begin
            word_q <= sram_rdata;
            byte_q <= sram_rdata[7:0];
          end
        end
        ST_SEND_LO: if (byte_ready && !last_lo) byte_q <= word_q[15:8];
        ST_SEND_HI: if (byte_ready && !at_stop) addr_q <= addr_q + 16'd1;
        ST_FINISH:  armed_q <= 1'b0;
        default:    ;
      endcase
    end
  end

  assign sram_addr = addr_q;
  assign sram_rw   = 1'b1;
  assign byte_data = byte_q;
  assign error     = error_q;

endmodule
